// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO Clause 22 PHY emulator: frame FSM states,
// opcodes, register addresses and register bit positions.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_START,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } mdio_state_e;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam logic [4:0] REG_BMCR     = 5'd0;
  localparam logic [4:0] REG_BMSR     = 5'd1;
  localparam logic [4:0] REG_ID1      = 5'd2;
  localparam logic [4:0] REG_ID2      = 5'd3;
  localparam logic [4:0] REG_ANAR     = 5'd4;
  localparam logic [4:0] SCRATCH_BASE = 5'd16;

  localparam int BMCR_RESET_BIT = 15;
  localparam int BMSR_LINK_BIT  = 2;

  // Scratch registers live at 16..16+numScratch-1, so bit 4 set plus an
  // in-range low nibble identifies one.
  function automatic logic isScratch(input logic [4:0] addr, input int numScratch);
    return addr[4] && (int'({1'b0, addr[3:0]}) < numScratch);
  endfunction

endpackage

// File: rtl/mdio_phy_regs.sv
// Register file of the emulated PHY: read mux, write decode, BMCR self-clear
// and the latch-low link status bit.
module mdio_phy_regs
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID1     = 16'h0022,
  parameter logic [15:0] PHY_ID2     = 16'h1619,
  parameter logic [15:0] BMCR_RST    = 16'h3100,
  parameter logic [15:0] BMSR_CAP    = 16'h7809,
  parameter logic [15:0] ANAR_RST    = 16'h01E1,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rdAddr,
  output logic [15:0] o_rdData,
  input  logic        i_wrEn,
  input  logic [4:0]  i_wrAddr,
  input  logic [15:0] i_wrData,
  input  logic        i_linkUp,
  input  logic        i_linkReload,
  output logic        o_wrStb,
  output logic [4:0]  o_wrAddr,
  output logic [15:0] o_wrData,
  output logic [15:0] o_bmcr
);

  // The self-reset bit must never read back as set.
  localparam logic [15:0] BMCR_INIT = BMCR_RST & 16'h7FFF;

  logic [15:0] r_bmcr;
  logic [15:0] r_anar;
  logic [15:0] r_scratch [16];
  logic        r_link;

  assign o_bmcr = r_bmcr;

  // Commit accepted writes, publish the write strobe and track the link latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bmcr   <= BMCR_INIT;
      r_anar   <= ANAR_RST;
      r_link   <= 1'b0;
      o_wrStb  <= 1'b0;
      o_wrAddr <= '0;
      o_wrData <= '0;
      for (int i = 0; i < 16; i++) r_scratch[i] <= '0;
    end else begin
      o_wrStb <= i_wrEn;
      if (i_wrEn) begin
        o_wrAddr <= i_wrAddr;
        o_wrData <= i_wrData;
        if (i_wrAddr == REG_BMCR) begin
          if (i_wrData[BMCR_RESET_BIT]) begin
            r_bmcr <= BMCR_INIT;
            r_anar <= ANAR_RST;
          end else begin
            r_bmcr <= i_wrData;
          end
        end else if (i_wrAddr == REG_ANAR) begin
          r_anar <= i_wrData;
        end else if (isScratch(i_wrAddr, NUM_SCRATCH)) begin
          r_scratch[i_wrAddr[3:0]] <= i_wrData;
        end
      end
      if (!i_linkUp) begin
        r_link <= 1'b0;
      end else if (i_linkReload) begin
        r_link <= 1'b1;
      end
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    o_rdData = '0;
    case (i_rdAddr)
      REG_BMCR: o_rdData = r_bmcr;
      REG_BMSR: begin
        o_rdData = BMSR_CAP;
        o_rdData[BMSR_LINK_BIT] = r_link;
      end
      REG_ID1:  o_rdData = PHY_ID1;
      REG_ID2:  o_rdData = PHY_ID2;
      REG_ANAR: o_rdData = r_anar;
      default: begin
        if (isScratch(i_rdAddr, NUM_SCRATCH)) o_rdData = r_scratch[i_rdAddr[3:0]];
      end
    endcase
  end

endmodule

// File: rtl/mdio_phy_emu.sv
// MDIO Clause 22 PHY emulator top: frame FSM, address/data shifters and the
// registered MDIO driver, wrapped around the register file.
module mdio_phy_emu
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd8,
  parameter bit          ACCEPT_BCAST = 1'b0,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1619,
  parameter logic [15:0] BMCR_RST     = 16'h3100,
  parameter logic [15:0] BMSR_CAP     = 16'h7809,
  parameter logic [15:0] ANAR_RST     = 16'h01E1,
  parameter int          NUM_SCRATCH  = 4
) (
  input  logic        mdio_clk,
  input  logic        mdio_rst,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] bmcr
);

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  mdio_state_e r_state;
  logic [5:0]  r_preCnt;
  logic [3:0]  r_bitCnt;
  logic        r_opHi;
  logic        r_isRead;
  logic [4:0]  r_phyad;
  logic [4:0]  r_regad;
  logic [15:0] r_dataSh;
  logic [15:0] r_rdShift;
  logic        r_wrPend;
  logic        r_linkReload;
  logic        r_mdioO;
  logic        r_mdioOe;
  logic        w_match;
  logic        w_drive;
  logic [15:0] w_rdData;

  assign w_match = (r_phyad == PHY_ADDR) || (ACCEPT_BCAST && (r_phyad == 5'd0));
  assign w_drive = r_isRead && w_match;
  assign mdio_o  = r_mdioO;
  assign mdio_oe = r_mdioOe;

  // Frame decoder; the MDIO driver is computed from state only so the output
  // never depends combinationally on mdio_i.
  always_ff @(posedge mdio_clk) begin
    if (mdio_rst) begin
      r_state      <= S_PRE;
      r_preCnt     <= '0;
      r_bitCnt     <= '0;
      r_wrPend     <= 1'b0;
      r_linkReload <= 1'b0;
      r_mdioO      <= 1'b1;
      r_mdioOe     <= 1'b0;
    end else begin
      r_wrPend     <= 1'b0;
      r_linkReload <= 1'b0;
      r_mdioO      <= 1'b1;
      r_mdioOe     <= 1'b0;
      case (r_state)
        S_PRE: begin
          if (mdio_i) begin
            if (r_preCnt < PRE_MIN) r_preCnt <= r_preCnt + 6'd1;
          end else if (r_preCnt >= PRE_MIN) begin
            r_state  <= S_START;
            r_preCnt <= '0;
          end else begin
            r_preCnt <= '0;
          end
        end
        S_START: begin
          r_bitCnt <= '0;
          r_state  <= mdio_i ? S_OP : S_PRE;
        end
        S_OP: begin
          if (r_bitCnt == 4'd0) begin
            r_opHi   <= mdio_i;
            r_bitCnt <= 4'd1;
          end else begin
            r_bitCnt <= '0;
            if ({r_opHi, mdio_i} == OP_RD) begin
              r_isRead <= 1'b1;
              r_state  <= S_PHYAD;
            end else if ({r_opHi, mdio_i} == OP_WR) begin
              r_isRead <= 1'b0;
              r_state  <= S_PHYAD;
            end else begin
              r_state <= S_PRE;
            end
          end
        end
        S_PHYAD: begin
          r_phyad <= {r_phyad[3:0], mdio_i};
          if (r_bitCnt == 4'd4) begin
            r_bitCnt <= '0;
            r_state  <= S_REGAD;
          end else begin
            r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
        S_REGAD: begin
          r_regad <= {r_regad[3:0], mdio_i};
          if (r_bitCnt == 4'd4) begin
            r_bitCnt <= '0;
            r_state  <= S_TA;
          end else begin
            r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
        S_TA: begin
          if (r_bitCnt == 4'd0) begin
            r_rdShift <= w_rdData;
            r_bitCnt  <= 4'd1;
          end else begin
            r_bitCnt <= '0;
            r_state  <= S_DATA;
            if (w_drive) begin
              r_mdioOe <= 1'b1;
              r_mdioO  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          r_dataSh <= {r_dataSh[14:0], mdio_i};
          if (w_drive) begin
            r_mdioOe  <= 1'b1;
            r_mdioO   <= r_rdShift[15];
            r_rdShift <= {r_rdShift[14:0], 1'b0};
          end
          if (r_bitCnt == 4'd15) begin
            r_bitCnt     <= '0;
            r_state      <= S_PRE;
            r_wrPend     <= !r_isRead && w_match;
            r_linkReload <= w_drive && (r_regad == REG_BMSR);
          end else begin
            r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
        default: r_state <= S_PRE;
      endcase
    end
  end

  mdio_phy_regs #(
    .PHY_ID1     (PHY_ID1),
    .PHY_ID2     (PHY_ID2),
    .BMCR_RST    (BMCR_RST),
    .BMSR_CAP    (BMSR_CAP),
    .ANAR_RST    (ANAR_RST),
    .NUM_SCRATCH (NUM_SCRATCH)
  ) u_regs (
    .i_clk        (mdio_clk),
    .i_rst        (mdio_rst),
    .i_rdAddr     (r_regad),
    .o_rdData     (w_rdData),
    .i_wrEn       (r_wrPend),
    .i_wrAddr     (r_regad),
    .i_wrData     (r_dataSh),
    .i_linkUp     (link_up),
    .i_linkReload (r_linkReload),
    .o_wrStb      (wr_stb),
    .o_wrAddr     (wr_addr),
    .o_wrData     (wr_data),
    .o_bmcr       (bmcr)
  );

endmodule

// File: tb/tb_mdio_phy_emu.sv
// Bench for mdio_phy_emu: a MAC-side bit driver, a register-map reference
// model and two PHYs (unicast only, and broadcast-enabled) on one bus.
module tb_mdio_phy_emu;

  logic        mdio_clk = 1'b0;
  logic        mdio_rst;
  logic        mdio_i;
  logic        link_up;
  logic        aO, aOe, aStb, bO, bOe, bStb;
  logic [4:0]  aWrAddr, bWrAddr;
  logic [15:0] aWrData, aBmcr, bWrData, bBmcr;

  int nChecks  = 0;
  int nErrors  = 0;
  int stbCount = 0;

  logic trOeA [19];
  logic trOA  [19];
  logic trOeB [19];
  logic trOB  [19];
  logic stbAtM1, stbAtM2;

  logic [15:0] modelRegs [32];
  logic        modelLink;

  mdio_phy_emu dutA (
    .mdio_clk(mdio_clk), .mdio_rst(mdio_rst), .mdio_i(mdio_i),
    .mdio_o(aO), .mdio_oe(aOe), .link_up(link_up), .wr_stb(aStb),
    .wr_addr(aWrAddr), .wr_data(aWrData), .bmcr(aBmcr)
  );

  mdio_phy_emu #(.ACCEPT_BCAST(1'b1)) dutB (
    .mdio_clk(mdio_clk), .mdio_rst(mdio_rst), .mdio_i(mdio_i),
    .mdio_o(bO), .mdio_oe(bOe), .link_up(link_up), .wr_stb(bStb),
    .wr_addr(bWrAddr), .wr_data(bWrData), .bmcr(bBmcr)
  );

  // Free-running MDC.
  always #5 mdio_clk = ~mdio_clk;

  // Count write strobes of the unicast PHY, sampled mid-cycle.
  always @(negedge mdio_clk) if (aStb) stbCount++;

  // Register map as a driver sees it after reset.
  task automatic modelReset();
    for (int i = 0; i < 32; i++) modelRegs[i] = 16'h0000;
    modelRegs[0] = 16'h3100;
    modelRegs[2] = 16'h0022;
    modelRegs[3] = 16'h1619;
    modelRegs[4] = 16'h01E1;
    modelLink = 1'b0;
  endtask

  task automatic modelWrite(input logic [4:0] addr, input logic [15:0] data);
    if (addr == 5'd0) begin
      if (data[15]) begin
        modelRegs[0] = 16'h3100;
        modelRegs[4] = 16'h01E1;
      end else begin
        modelRegs[0] = data;
      end
    end else if (addr == 5'd4 || (addr >= 5'd16 && addr <= 5'd19)) begin
      modelRegs[addr] = data;
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [4:0] addr);
    if (addr == 5'd1) return 16'h7809 | (modelLink ? 16'h0004 : 16'h0000);
    return modelRegs[addr];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive n bits of val MSB first, one per rising edge; returns #1 after the edge.
  task automatic applyStimulus(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mdio_i = val[i];
      @(posedge mdio_clk);
      #1;
    end
  endtask

  task automatic sendOnes(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'd1, 1);
  endtask

  // Read frame; records both PHYs' drivers for TA1, TA2, 16 data bits and the edge after.
  task automatic readFrame(input logic [4:0] phy, input logic [4:0] regad, input int preLen);
    sendOnes(preLen);
    applyStimulus(32'({2'b01, 2'b10, phy, regad}), 14);
    mdio_i = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(posedge mdio_clk);
      #1;
      trOeA[i] = aOe;
      trOA[i]  = aO;
      trOeB[i] = bOe;
      trOB[i]  = bO;
    end
  endtask

  task automatic writeFrame(input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] data);
    sendOnes(32);
    applyStimulus(32'({2'b01, 2'b01, phy, regad, 2'b10}), 16);
    applyStimulus(32'(data), 16);
    mdio_i = 1'b1;
    @(posedge mdio_clk);
    #1;
    stbAtM1 = aStb;
    @(posedge mdio_clk);
    #1;
    stbAtM2 = aStb;
  endtask

  task automatic checkRead(input string tag, input logic useB, input logic expDrive,
                           input logic [15:0] expData);
    logic oe [19];
    logic o  [19];
    logic [15:0] word;
    logic oeAll, oeAny;
    for (int i = 0; i < 19; i++) begin
      oe[i] = useB ? trOeB[i] : trOeA[i];
      o[i]  = useB ? trOB[i]  : trOA[i];
    end
    oeAll = 1'b1;
    oeAny = 1'b0;
    for (int i = 0; i < 19; i++) oeAny = oeAny | oe[i];
    for (int i = 0; i < 16; i++) begin
      word[15 - i] = o[i + 2];
      oeAll = oeAll & oe[i + 2];
    end
    if (expDrive) begin
      checkOutput({tag, "_ta1_oe"}, 32'(oe[0]), 32'd0);
      checkOutput({tag, "_ta2_oe_o"}, 32'({oe[1], o[1]}), 32'b10);
      checkOutput({tag, "_data"}, 32'(word), 32'(expData));
      checkOutput({tag, "_data_oe"}, 32'(oeAll), 32'd1);
      checkOutput({tag, "_end_oe"}, 32'(oe[18]), 32'd0);
    end else begin
      checkOutput({tag, "_nodrive"}, 32'(oeAny), 32'd0);
    end
  endtask

  // Directed scenarios, a randomized model-checked phase, then reset mid-read.
  initial begin
    int          kind;
    int          stbBefore;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] d;

    mdio_rst = 1'b1;
    mdio_i   = 1'b1;
    link_up  = 1'b1;
    repeat (3) @(posedge mdio_clk);
    #1;
    modelReset();
    checkOutput("rst_oe", 32'(aOe), 32'd0);
    checkOutput("rst_o", 32'(aO), 32'd1);
    checkOutput("rst_wr_stb", 32'(aStb), 32'd0);
    checkOutput("rst_wr_addr", 32'(aWrAddr), 32'd0);
    checkOutput("rst_wr_data", 32'(aWrData), 32'd0);
    checkOutput("rst_bmcr", 32'(aBmcr), 32'h3100);
    mdio_rst = 1'b0;

    readFrame(5'd8, 5'd2, 32);
    checkRead("id1_A", 1'b0, 1'b1, 16'h0022);
    checkRead("id1_B", 1'b1, 1'b1, 16'h0022);

    stbBefore = stbCount;
    writeFrame(5'd8, 5'd16, 16'hA5A5);
    modelWrite(5'd16, 16'hA5A5);
    checkOutput("scr_stb_m1", 32'(stbAtM1), 32'd1);
    checkOutput("scr_stb_m2", 32'(stbAtM2), 32'd0);
    checkOutput("scr_stb_count", 32'(stbCount - stbBefore), 32'd1);
    checkOutput("scr_wr_addr", 32'(aWrAddr), 32'd16);
    checkOutput("scr_wr_data", 32'(aWrData), 32'hA5A5);
    readFrame(5'd8, 5'd16, 32);
    checkRead("scr_rd", 1'b0, 1'b1, modelRead(5'd16));

    writeFrame(5'd8, 5'd4, 16'h1234);
    modelWrite(5'd4, 16'h1234);
    writeFrame(5'd8, 5'd0, 16'h1200);
    modelWrite(5'd0, 16'h1200);
    checkOutput("bmcr_plain", 32'(aBmcr), 32'h1200);
    writeFrame(5'd8, 5'd0, 16'h8000);
    modelWrite(5'd0, 16'h8000);
    checkOutput("bmcr_selfrst", 32'(aBmcr), 32'h3100);
    readFrame(5'd8, 5'd0, 32);
    checkRead("bmcr_rd", 1'b0, 1'b1, modelRead(5'd0));
    readFrame(5'd8, 5'd4, 32);
    checkRead("anar_rd", 1'b0, 1'b1, modelRead(5'd4));

    link_up = 1'b0;
    sendOnes(1);
    modelLink = 1'b0;
    link_up = 1'b1;
    readFrame(5'd8, 5'd1, 32);
    checkRead("bmsr_first", 1'b0, 1'b1, modelRead(5'd1));
    modelLink = link_up;
    readFrame(5'd8, 5'd1, 32);
    checkRead("bmsr_second", 1'b0, 1'b1, modelRead(5'd1));
    modelLink = link_up;

    applyStimulus(32'd0, 1);
    readFrame(5'd8, 5'd2, 31);
    checkRead("short_pre_A", 1'b0, 1'b0, 16'h0000);
    checkRead("short_pre_B", 1'b1, 1'b0, 16'h0000);

    readFrame(5'd5, 5'd2, 32);
    checkRead("phy5_rd", 1'b0, 1'b0, 16'h0000);
    stbBefore = stbCount;
    writeFrame(5'd5, 5'd17, 16'h5A5A);
    checkOutput("phy5_wr_stb", 32'(stbCount - stbBefore), 32'd0);

    readFrame(5'd0, 5'd3, 32);
    checkRead("bcast_A", 1'b0, 1'b0, 16'h0000);
    checkRead("bcast_B", 1'b1, 1'b1, 16'h1619);

    sendOnes(32);
    applyStimulus(32'b0111, 4);
    applyStimulus(32'($urandom_range(0, 65535)), 16);
    readFrame(5'd8, 5'd2, 32);
    checkRead("after_op11", 1'b0, 1'b1, 16'h0022);

    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      phy  = ($urandom_range(0, 4) == 0) ? 5'd5 : 5'd8;
      ra   = ($urandom_range(0, 1) != 0) ? 5'(16 + $urandom_range(0, 3))
                                         : 5'($urandom_range(0, 31));
      d    = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        link_up = 1'b0;
        sendOnes(1);
        modelLink = 1'b0;
        link_up = 1'b1;
      end
      if (kind == 0) begin
        stbBefore = stbCount;
        writeFrame(phy, ra, d);
        if (phy == 5'd8) begin
          modelWrite(ra, d);
          checkOutput($sformatf("rnd%0d_wr_stb", it), 32'(stbCount - stbBefore), 32'd1);
          checkOutput($sformatf("rnd%0d_wr_data", it), 32'({aWrAddr, aWrData}), 32'({ra, d}));
          checkOutput($sformatf("rnd%0d_bmcr", it), 32'(aBmcr), 32'(modelRegs[0]));
        end else begin
          checkOutput($sformatf("rnd%0d_wr_stb", it), 32'(stbCount - stbBefore), 32'd0);
        end
      end else begin
        readFrame(phy, ra, 32);
        checkRead($sformatf("rnd%0d_rd", it), 1'b0, phy == 5'd8, modelRead(ra));
        if (phy == 5'd8 && ra == 5'd1) modelLink = link_up;
      end
    end

    writeFrame(5'd8, 5'd4, 16'h0DE1);
    modelWrite(5'd4, 16'h0DE1);
    sendOnes(32);
    applyStimulus(32'({2'b01, 2'b10, 5'd8, 5'd3}), 14);
    mdio_i = 1'b1;
    repeat (7) begin
      @(posedge mdio_clk);
      #1;
    end
    checkOutput("midrd_oe", 32'(aOe), 32'd1);
    mdio_rst = 1'b1;
    @(posedge mdio_clk);
    #1;
    checkOutput("midrd_rst_oe", 32'(aOe), 32'd0);
    @(posedge mdio_clk);
    #1;
    mdio_rst = 1'b0;
    modelReset();
    checkOutput("midrd_bmcr", 32'(aBmcr), 32'h3100);
    checkOutput("midrd_wr", 32'({aStb, aWrAddr, aWrData}), 32'd0);
    readFrame(5'd8, 5'd4, 32);
    checkRead("midrd_anar", 1'b0, 1'b1, modelRead(5'd4));
    readFrame(5'd8, 5'd16, 32);
    checkRead("midrd_scr", 1'b0, 1'b1, modelRead(5'd16));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mdio_phy_emu.md
# mdio_phy_emu

Parametrised MDIO (IEEE 802.3 Clause 22) PHY emulator for the MAC-to-MAC bridge. It presents a fake PHY to a MAC's management interface so that MAC drivers can find a PHY, read its ID and link state, and write control and scratch registers. It is the successor of the read-only ROM responder and adds:

- preamble checking
- write frames with a host-side write strobe
- writable and self-clearing BMCR
- latch-low link status
- broadcast address
- a configurable scratch register bank

## Interface
- `PHY_ADDR`, 8: PHY address this block answers to (5 bits).
- `ACCEPT_BCAST`, 0: 1 makes the block also answer PHY address 0.
- `PREAMBLE_MIN`, 32: consecutive 1s required before ST. Legal range 1..32.
- `PHY_ID1`, 16'h0022: register 2 value.
- `PHY_ID2`, 16'h1619: register 3 value.
- `BMCR_RST`, 16'h3100: BMCR value after reset and after a BMCR.15 self-reset.
- `BMSR_CAP`, 16'h7809: BMSR value excluding bit 2.
- `ANAR_RST`, 16'h01E1: register 4 value after reset.
- `NUM_SCRATCH`, 4: scratch registers at addresses 16..16+NUM_SCRATCH-1. Legal range 0..16.

Ports:
- `mdio_clk`, in, 1: MDC. All logic runs on its rising edge.
- `mdio_rst`, in, 1: reset, synchronous, active-high.
- `mdio_i`, in, 1: sampled MDIO.
- `mdio_o`, out, 1: MDIO drive value. Reads 1 when not driving.
- `mdio_oe`, out, 1: MDIO output enable.
- `link_up`, in, 1: live link indication, synchronous to mdio_clk.
- `wr_stb`, out, 1: one-cycle pulse per accepted write frame.
- `wr_addr`, out, 5: register address of the last accepted write.
- `wr_data`, out, 16: data of the last accepted write.
- `bmcr`, out, 16: current BMCR contents.

## Operation
- FSM states and transitions:
  - PRE: count consecutive 1s, saturating at PREAMBLE_MIN. A sampled 0 with count ≥ PREAMBLE_MIN goes to ST. A sampled 0 with count below the minimum clears the count.
  - ST: sampled bit must be 1. Otherwise go to PRE with count 0.
  - OP: 2 bits. 10 means read, 01 means write. 00 and 11 (Clause 45) go to PRE with count 0.
  - PHYAD: 5 bits, MSB first.
  - REGAD: 5 bits, MSB first.
  - TA: 2 bits.
  - DATA: 16 bits, then go to PRE with count 0.
- Address match: PHYAD == PHY_ADDR, or PHYAD == 0 when ACCEPT_BCAST is set. On a mismatch the frame is still tracked to the end of DATA and the block neither drives nor writes.
- Register map for reads; all other addresses read 0:
  - 0: BMCR
  - 1: BMSR_CAP with bit 2 = latched link
  - 2: PHY_ID1
  - 3: PHY_ID2
  - 4: ANAR
  - 16+: scratch
- Writes:
  - Writable registers: 0, 4 and scratch. Writes to any other address are dropped, but `wr_stb` still pulses.
  - BMCR.15 is self-clearing. Writing it with 1 loads BMCR_RST (bit 15 = 0) and resets ANAR to ANAR_RST. The other written bits are discarded.
- Latched link (BMSR.2):
  - Cleared on any cycle where `link_up` = 0.
  - Reloaded from `link_up` on the cycle after the last data bit of a matched BMSR read.
  - Reset value is 0.
- TA bits of a write frame are not checked.

## Timing
- Let edge N sample the last REGAD bit of a matched read.
  - Cycle N+1 (TA1): `mdio_oe` = 0.
  - Cycle N+2 (TA2): `mdio_oe` = 1, `mdio_o` = 0.
  - Cycles N+3..N+18: data MSB first.
  - Cycle N+19: `mdio_oe` = 0.
- Read data is snapshotted at the TA1 edge. A link drop during DATA does not alter the bits already snapshotted.
- `mdio_o` and `mdio_oe` are registered. No combinational path from `mdio_i`.
- Write: let edge M sample the last data bit.
  - Register contents, `wr_addr`, `wr_data` and `bmcr` update at edge M+1.
  - `wr_stb` is high for the single cycle M+1..M+2.
- A new frame may follow with its preamble immediately after DATA.
- Reset values:
  - FSM in PRE with count 0.
  - `mdio_oe` = 0, `mdio_o` = 1.
  - `wr_stb` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `bmcr` = BMCR_RST, ANAR = ANAR_RST, scratch = 0, latched link = 0.
- Reset mid-frame: the frame is aborted, `mdio_oe` drops at the next edge, and no write is committed.

## Structure
- Shared package `mdio_pkg` holds:
  - FSM state encoding
  - opcode constants OP_RD = 2'b10, OP_WR = 2'b01
  - register address constants (BMCR, BMSR, ID1, ID2, ANAR, SCRATCH_BASE)
  - BMCR/BMSR bit indices
- One sub-module, `mdio_phy_regs`: the register file with its read mux, write decode, BMCR self-clear and link latch.
- The top level holds the frame FSM and shift registers.

## Test plan
- 32 ones, then a read of reg 2 at PHY 8: TA1 not driven, TA2 drives 0, then 16'h0022 MSB first, then `oe` drops.
- Write 16'hA5A5 to reg 16, then read it back:
  - `wr_stb` pulses once with `wr_addr` = 16.
  - The read returns 16'hA5A5.
- Write BMCR 16'h8000: the BMCR read afterwards returns 16'h3100, and ANAR is back to 16'h01E1.
- Link latch:
  - `link_up` pulses 0 for 1 cycle, then stays 1.
  - First BMSR read shows bit 2 = 0; second shows bit 2 = 1.
- Rejected frames:
  - 31-bit preamble with PREAMBLE_MIN = 32 → no drive.
  - Frames addressed to PHY 5 → no drive, no `wr_stb`.
  - PHY 0 with ACCEPT_BCAST = 1 → responds.
- Error recovery and reset:
  - OP = 11 → block drops to PRE, and the next valid frame is answered.
  - `mdio_rst` asserted at data bit 5 of a read → `oe` = 0 next edge, and registers return to defaults.
